// File: rtl/d_phy_tx_lane_scheduler.sv
// rtl/d_phy_tx_lane_scheduler.sv - schedules one HS burst across the active D-PHY data lanes
// Clock lane request brackets the data lane requests; the last word may use fewer lanes.
module d_phy_tx_lane_scheduler #(
    parameter int N_DATA_LANES         = 4,
    parameter int HS_TX_WORD_BIT_WIDTH = 8,
    parameter int BURST_W              = 16,
    parameter int CLK_PRE_CYCLES       = 2,
    parameter int CLK_POST_CYCLES      = 3,
    localparam int LW = $clog2(N_DATA_LANES + 1),
    localparam int DW = N_DATA_LANES * HS_TX_WORD_BIT_WIDTH
) (
    input  logic                    hs_tx_word_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [LW-1:0]           active_lanes,
    input  logic                    burst_req,
    input  logic [BURST_W-1:0]      burst_bytes,
    output logic                    burst_ack,
    output logic                    burst_done,
    output logic                    busy,
    output logic                    underrun,
    output logic                    stop_state,
    input  logic [DW-1:0]           s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    clk_tx_request_hs,
    input  logic                    clk_tx_ready_hs,
    input  logic                    clk_stop_state,
    output logic [N_DATA_LANES-1:0] dl_tx_request_hs,
    output logic [DW-1:0]           dl_tx_data_hs,
    input  logic [N_DATA_LANES-1:0] dl_tx_ready_hs,
    input  logic [N_DATA_LANES-1:0] dl_stop_state
);

    localparam int CNT_W = 8;
    localparam int W     = HS_TX_WORD_BIT_WIDTH;

    typedef enum logic [2:0] {
        IDLE, LOAD, CLK_WAIT, CLK_PRE, DATA, DATA_END, CLK_POST, CLK_OFF
    } state_t;

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   rem_q, rem_d;
    logic [LW-1:0]        lanes_q, lanes_d;
    logic [DW-1:0]        word_q, word_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;
    logic                 underrun_q, underrun_d;

    logic [LW-1:0]           lanes_now;
    logic [N_DATA_LANES-1:0] lane_mask;
    logic [N_DATA_LANES-1:0] dl_req;
    logic                    advance;
    logic                    accept;

    assign stop_state = clk_stop_state & (&dl_stop_state);
    assign busy       = (state_q != IDLE);
    assign burst_ack  = ack_q;
    assign burst_done = done_q;
    assign underrun   = underrun_q;
    assign dl_tx_request_hs = dl_req;

    assign accept = burst_req & enable & stop_state & (burst_bytes != '0)
                  & (active_lanes != '0) & (active_lanes <= LW'(N_DATA_LANES));

    always_comb begin
        lanes_now = (rem_q < BURST_W'(lanes_q)) ? rem_q[LW-1:0] : lanes_q;
        lane_mask = '0;
        for (int i = 0; i < N_DATA_LANES; i++) begin
            lane_mask[i] = (LW'(i) < lanes_now);
        end
    end

    assign advance = (|dl_req) & (&(dl_tx_ready_hs | ~dl_req));

    // Lanes without a request on the current word drive zeros.
    always_comb begin
        dl_tx_data_hs = '0;
        for (int i = 0; i < N_DATA_LANES; i++) begin
            if (dl_req[i]) begin
                dl_tx_data_hs[i*W +: W] = word_q[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rem_d             = rem_q;
        lanes_d           = lanes_q;
        word_d            = word_q;
        cnt_d             = cnt_q;
        ack_d             = 1'b0;
        done_d            = 1'b0;
        underrun_d        = 1'b0;
        s_ready           = 1'b0;
        clk_tx_request_hs = 1'b0;
        dl_req            = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = burst_bytes;
                    lanes_d = active_lanes;
                    ack_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                clk_tx_request_hs = 1'b1;
                s_ready           = s_valid;
                if (s_valid) begin
                    word_d = s_data;
                end
                state_d = CLK_WAIT;
            end
            CLK_WAIT: begin
                clk_tx_request_hs = 1'b1;
                if (clk_tx_ready_hs) begin
                    if (CLK_PRE_CYCLES == 0) begin
                        state_d = DATA;
                    end else begin
                        cnt_d   = CNT_W'(CLK_PRE_CYCLES);
                        state_d = CLK_PRE;
                    end
                end
            end
            CLK_PRE: begin
                clk_tx_request_hs = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                clk_tx_request_hs = 1'b1;
                dl_req            = lane_mask;
                if (advance) begin
                    rem_d = rem_q - BURST_W'(lanes_now);
                    if (rem_d == '0) begin
                        state_d = DATA_END;
                    end else begin
                        // Ready is offered even when empty; an empty FIFO aborts the burst.
                        s_ready = 1'b1;
                        if (s_valid) begin
                            word_d = s_data;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = DATA_END;
                        end
                    end
                end
            end
            DATA_END: begin
                clk_tx_request_hs = 1'b1;
                if (dl_tx_ready_hs == '0) begin
                    if (CLK_POST_CYCLES == 0) begin
                        state_d = CLK_OFF;
                    end else begin
                        cnt_d   = CNT_W'(CLK_POST_CYCLES);
                        state_d = CLK_POST;
                    end
                end
            end
            CLK_POST: begin
                clk_tx_request_hs = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = CLK_OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CLK_OFF: begin
                if (stop_state) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hs_tx_word_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            lanes_q    <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            lanes_q    <= lanes_d;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_d_phy_tx_lane_scheduler.sv
// tb/tb_d_phy_tx_lane_scheduler.sv - self-checking bench for d_phy_tx_lane_scheduler
module tb_d_phy_tx_lane_scheduler;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int BW   = 16;
    localparam int PRE  = 2;
    localparam int POST = 3;
    localparam int LW   = 3;
    localparam int DW   = N * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic [LW-1:0] active_lanes;
    logic          burst_req;
    logic [BW-1:0] burst_bytes;
    logic          burst_ack, burst_done, busy, underrun, stop_state;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic          clk_tx_request_hs, clk_tx_ready_hs, clk_stop_state;
    logic [N-1:0]  dl_tx_request_hs, dl_tx_ready_hs, dl_stop_state;
    logic [DW-1:0] dl_tx_data_hs;

    d_phy_tx_lane_scheduler #(
        .N_DATA_LANES(N), .HS_TX_WORD_BIT_WIDTH(W), .BURST_W(BW),
        .CLK_PRE_CYCLES(PRE), .CLK_POST_CYCLES(POST)
    ) dut (
        .hs_tx_word_clk(clk), .rst(rst), .enable(enable), .active_lanes(active_lanes),
        .burst_req(burst_req), .burst_bytes(burst_bytes), .burst_ack(burst_ack),
        .burst_done(burst_done), .busy(busy), .underrun(underrun), .stop_state(stop_state),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clk_tx_request_hs(clk_tx_request_hs), .clk_tx_ready_hs(clk_tx_ready_hs),
        .clk_stop_state(clk_stop_state), .dl_tx_request_hs(dl_tx_request_hs),
        .dl_tx_data_hs(dl_tx_data_hs), .dl_tx_ready_hs(dl_tx_ready_hs),
        .dl_stop_state(dl_stop_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] fifo_mem [0:63];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    int   cur_bytes = 0;
    int   cur_l = 0;
    logic force_stop1_low = 1'b0;

    int   m_rem = 0, m_l = 0, m_idx = 0, m_base = 0, n_now = 0, cyc = 0;
    logic exp_ur = 1'b0, pop_pending = 1'b0, data_seen = 1'b0, prev_clk_rdy = 1'b0;
    logic clk_req_prev = 1'b0;
    logic [N-1:0]  dl_req_prev = '0;
    logic [N-1:0]  req_or = '0, emask;
    logic [DW-1:0] edata, eword;
    int   adv_cnt = 0, consumed = 0, ur_cnt = 0, done_cnt = 0;
    int   pre_gap = 0, clk_rdy_cyc = 0, tail = 0, last_tail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane/clock PHY models answer ready one cycle after request; stop follows ~ready.
    // The model predicts masks and words purely from byte count, lane count and FIFO contents.
    initial begin
        clk_tx_ready_hs = 1'b0;
        clk_stop_state  = 1'b1;
        dl_tx_ready_hs  = '0;
        dl_stop_state   = '1;
        s_valid         = 1'b0;
        s_data          = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pop_pending) begin
                rd_ptr++;
                pop_pending = 1'b0;
            end
            if (rst) rd_ptr = wr_ptr;
            s_valid = (rd_ptr < wr_ptr);
            s_data  = s_valid ? fifo_mem[rd_ptr] : '0;
            clk_tx_ready_hs = clk_req_prev;
            clk_req_prev    = clk_tx_request_hs;
            clk_stop_state  = !clk_tx_ready_hs;
            dl_tx_ready_hs  = dl_req_prev;
            dl_req_prev     = dl_tx_request_hs;
            dl_stop_state   = ~dl_tx_ready_hs;
            if (force_stop1_low) dl_stop_state[1] = 1'b0;
            #1;
            if (rst) begin
                m_rem  = 0;
                exp_ur = 1'b0;
            end else begin
                if (clk_tx_ready_hs && !prev_clk_rdy) clk_rdy_cyc = cyc;
                prev_clk_rdy = clk_tx_ready_hs;
                if (burst_ack) begin
                    m_rem = cur_bytes; m_l = cur_l; m_idx = 0; m_base = rd_ptr;
                    req_or = '0; data_seen = 1'b0; tail = 0;
                end
                if (s_ready && s_valid) begin
                    pop_pending = 1'b1;
                    consumed++;
                end
                if (underrun) ur_cnt++;
                if (busy || exp_ur) chk("underrun", underrun, exp_ur);
                if (underrun) chk("req_after_underrun", dl_tx_request_hs, 0);
                exp_ur = 1'b0;
                if (dl_tx_request_hs != '0) begin
                    if (!data_seen) begin
                        pre_gap   = cyc - clk_rdy_cyc;
                        data_seen = 1'b1;
                    end
                    n_now = (m_l < m_rem) ? m_l : m_rem;
                    eword = fifo_mem[(m_base + m_idx) % 64];
                    emask = '0;
                    edata = '0;
                    for (int i = 0; i < N; i++) begin
                        if (i < n_now) begin
                            emask[i] = 1'b1;
                            edata[i*W +: W] = eword[i*W +: W];
                        end
                    end
                    chk("dl_req_mask", dl_tx_request_hs, emask);
                    chk("dl_data", dl_tx_data_hs, edata);
                    chk("clk_req_during_data", clk_tx_request_hs, 1);
                    req_or |= dl_tx_request_hs;
                    if (&(dl_tx_ready_hs | ~dl_tx_request_hs)) begin
                        adv_cnt++;
                        m_rem -= n_now;
                        m_idx++;
                        chk("s_ready_on_advance", s_ready, m_rem > 0);
                        if (m_rem > 0 && !s_valid) begin
                            exp_ur = 1'b1;
                            m_rem  = 0;
                        end
                    end else begin
                        chk("s_ready_no_advance", s_ready, 0);
                    end
                end else if (data_seen && clk_tx_request_hs) begin
                    tail++;
                end
                if (burst_done) begin
                    done_cnt++;
                    last_tail = tail;
                    chk("rem_at_done", m_rem, 0);
                end
            end
        end
    end

    task automatic setup_burst(input int bytes, input int l, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            fifo_mem[wr_ptr + k] = {$urandom, $urandom};
        end
        wr_ptr      = wr_ptr + nwords;
        cur_bytes   = bytes;
        cur_l       = l;
        burst_bytes = BW'(bytes);
        active_lanes = LW'(l);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #1;
            if (burst_done) seen = 1'b1;
        end
        chk("burst_done_seen", seen, 1);
    endtask

    task automatic run_burst(input int bytes, input int l, input int nwords, input string tag,
                             input int exp_adv, input int exp_cons, input int exp_ur,
                             input logic [N-1:0] exp_or);
        int a0, c0, u0, d0;
        setup_burst(bytes, l, nwords);
        a0 = adv_cnt; c0 = consumed; u0 = ur_cnt; d0 = done_cnt;
        burst_req = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack_cycle1"}, burst_ack, 1);
        burst_req = 1'b0;
        wait_done();
        @(negedge clk); #2;
        chk({tag, "_advances"}, adv_cnt - a0, exp_adv);
        chk({tag, "_consumed"}, consumed - c0, exp_cons);
        chk({tag, "_underruns"}, ur_cnt - u0, exp_ur);
        chk({tag, "_dones"}, done_cnt - d0, 1);
        chk({tag, "_lanes_used"}, req_or, exp_or);
        chk({tag, "_pre_gap"}, pre_gap, PRE + 1);
        chk({tag, "_post_tail"}, last_tail, POST + 2);
    endtask

    task automatic expect_no_ack(input string tag);
        burst_req = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk({tag, "_no_ack"}, burst_ack, 0);
            chk({tag, "_idle"}, busy, 0);
        end
        burst_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        bit hit;
        rst = 1'b1; enable = 1'b1; burst_req = 1'b0;
        active_lanes = LW'(4); burst_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ack", burst_ack, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_clk_req", clk_tx_request_hs, 0);
        chk("rst_dl_req", dl_tx_request_hs, 0);
        chk("rst_dl_data", dl_tx_data_hs, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_stop_state", stop_state, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_burst(8, 4, 2, "b8_l4", 2, 2, 0, 4'b1111);
        run_burst(7, 4, 2, "b7_l4", 2, 2, 0, 4'b1111);
        run_burst(5, 2, 3, "b5_l2", 3, 3, 0, 4'b0011);
        run_burst(12, 4, 1, "b12_underrun", 1, 1, 1, 4'b1111);

        active_lanes = LW'(0); burst_bytes = BW'(4);
        expect_no_ack("lanes0");
        active_lanes = LW'(5);
        expect_no_ack("lanes5");
        active_lanes = LW'(4); burst_bytes = '0;
        expect_no_ack("bytes0");
        burst_bytes = BW'(4); enable = 1'b0;
        expect_no_ack("enable0");
        enable = 1'b1;

        force_stop1_low = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        setup_burst(2, 1, 2);
        burst_req = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("stop_low_no_ack", burst_ack, 0);
        end
        force_stop1_low = 1'b0;
        @(posedge clk); #1;
        chk("stop_release_ack", burst_ack, 1);
        burst_req = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("stop_test_lanes_used", req_or, 4'b0001);

        setup_burst(12, 4, 3);
        d0 = done_cnt;
        burst_req = 1'b1;
        @(posedge clk); #1;
        chk("rst_test_ack", burst_ack, 1);
        burst_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk); #1;
            if (dl_tx_request_hs != '0) hit = 1'b1;
        end
        chk("rst_test_reached_data", hit, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_dl_req", dl_tx_request_hs, 0);
        chk("midrst_clk_req", clk_tx_request_hs, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", burst_done, 0);
        chk("midrst_underrun", underrun, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done_pulse", done_cnt - d0, 0);
        repeat (4) @(posedge clk);
        #1;
        run_burst(4, 4, 1, "after_rst_b4", 1, 1, 0, 4'b1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/d_phy_tx_lane_scheduler.md
Name: d_phy_tx_lane_scheduler

Overview:
- Synthesizable, parametrised successor to the behavioural D-PHY master adapter sequencing.
- Takes a packed multi-lane word stream from the CSI protocol FIFO and schedules one HS burst across a runtime-selectable number of active data lanes.
- Sequences the Clock Lane PPI request around the Data Lane PPI requests.
- Supports burst lengths that are not a multiple of the lane count by ending individual lanes early. Flags FIFO underrun.

Parameters:
- N_DATA_LANES, 4, physical data lanes (1..8).
- HS_TX_WORD_BIT_WIDTH, 8, PPI TxDataHS width per lane.
- BURST_W, 16, width of the burst byte-count.
- CLK_PRE_CYCLES, 2, word-clock cycles between clock TxReadyHS and the first data request (0 allowed).
- CLK_POST_CYCLES, 3, word-clock cycles between all data TxReadyHS low and clock request release (0 allowed).

Ports:
- hs_tx_word_clk  in  1  word clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  PPI Enable; a burst starts only when high.
- active_lanes  in  $clog2(N_DATA_LANES+1)  lanes to use, 1..N_DATA_LANES; sampled at burst accept.
- burst_req  in  1  level request to start a burst.
- burst_bytes  in  BURST_W  burst byte count; sampled at accept.
- burst_ack  out  1  one-cycle pulse when a burst is accepted.
- burst_done  out  1  one-cycle pulse on return to IDLE.
- busy  out  1  high in every state except IDLE.
- underrun  out  1  one-cycle pulse on an abort caused by an empty FIFO.
- stop_state  out  1  clock stop-state AND all data stop-states.
- s_data  in  N_DATA_LANES*HS_TX_WORD_BIT_WIDTH  packed word; lane i occupies slice i.
- s_valid  in  1  word available.
- s_ready  out  1  word consumed this cycle.
- clk_tx_request_hs  out  1  Clock Lane TxRequestHS.
- clk_tx_ready_hs  in  1  Clock Lane TxReadyHS.
- clk_stop_state  in  1  Clock Lane Stopstate.
- dl_tx_request_hs  out  N_DATA_LANES  per-lane TxRequestHS.
- dl_tx_data_hs  out  N_DATA_LANES*HS_TX_WORD_BIT_WIDTH  per-lane TxDataHS.
- dl_tx_ready_hs  in  N_DATA_LANES  per-lane TxReadyHS.
- dl_stop_state  in  N_DATA_LANES  per-lane Stopstate.

Behaviour:
- Reset state: every output 0 except stop_state, which stays combinational. FSM goes to IDLE; counters and the word register clear. Reset mid-burst drops all requests on the next edge, with no burst_done and no underrun pulse.
- Definitions:
  - rem: remaining byte count.
  - L: latched active lanes.
  - lanes_now = min(L, rem).
  - lane_mask = bits [lanes_now-1:0] set.
  - advance = &(dl_tx_ready_hs | ~dl_tx_request_hs) while any request is high.
- IDLE:
  - Accept when burst_req & enable & stop_state & burst_bytes!=0 & 1<=active_lanes<=N_DATA_LANES.
  - On accept: latch rem and L, pulse burst_ack, go to LOAD.
  - Invalid active_lanes or zero bytes: request ignored, no ack.
- LOAD:
  - s_ready = s_valid; capture the word.
  - Assert clk_tx_request_hs in the same cycle, go to CLK_WAIT.
  - The clock request is held until CLK_OFF.
- CLK_WAIT:
  - Wait for clk_tx_ready_hs, then load the counter with CLK_PRE_CYCLES and go to CLK_PRE.
  - With CLK_PRE_CYCLES=0, go directly to DATA.
- CLK_PRE: count down; at 0 go to DATA.
- DATA, request and data outputs:
  - dl_tx_request_hs = lane_mask.
  - dl_tx_data_hs shows the word register; lanes outside lane_mask show 0.
- DATA, on advance:
  - rem -= lanes_now.
  - If the new rem==0, go to DATA_END; s_ready stays 0.
  - Otherwise s_ready=1 combinationally in the advance cycle and the word register loads s_data.
  - If s_valid=0 at that point: underrun pulse, all data requests drop next cycle, go to DATA_END.
- DATA, last word: a shrinking lane_mask on the last word deasserts the request of lanes that have no byte left, while the other lanes continue.
- DATA_END:
  - All dl_tx_request_hs = 0.
  - Wait until dl_tx_ready_hs == 0, then load the counter with CLK_POST_CYCLES and go to CLK_POST.
- CLK_POST: count down; at 0 go to CLK_OFF.
- CLK_OFF:
  - clk_tx_request_hs = 0.
  - Wait for stop_state, then pulse burst_done and go to IDLE.
- Arithmetic:
  - rem is BURST_W bits and never underflows, because lanes_now <= rem.
  - Word count per burst = ceil(burst_bytes/L).
- Boundary conditions:
  - burst_req held high after done starts the next burst only after re-entering IDLE; minimum one IDLE cycle.
  - enable is sampled only in IDLE.
  - s_valid outside LOAD/advance is ignored.

Test Plan:
- N=4, L=4, 8 bytes, FIFO full, lane models return ready 1 cycle after request:
  - burst_ack in cycle 1.
  - dl request 4'b1111 for exactly 2 advances.
  - 2 words consumed, burst_done, underrun=0.
- L=4, 7 bytes:
  - Word 1 mask 1111.
  - Word 2 mask 0111, lane 3 request drops at the word-2 boundary.
  - Total rem reaches 0 after 2 advances.
- L=2, 5 bytes, N=4:
  - Masks 0011, 0011, 0001.
  - Lanes 2-3 never requested; 3 words consumed.
- 12-byte burst, L=4, FIFO empty before word 2:
  - underrun pulses once.
  - Data requests drop the next cycle.
  - Clock released after CLK_POST_CYCLES; burst_done pulses.
- dl_stop_state[1]=0 in IDLE with burst_req high: no burst_ack until it rises, then ack the following cycle.
- rst asserted during DATA:
  - All requests 0 and busy 0 on the next edge.
  - No burst_done.
  - A new 4-byte burst afterwards completes normally.
